// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO producer for the execute stage.
// Multiplies and moves write in the cycle after acceptance. Divides run a
// 32-iteration restoring engine on operand magnitudes, hold busy for 32
// cycles and write in the 33rd cycle after acceptance. Every output is a flop.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [1:0]  we_o
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_DIVIDE = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] rq_q, rq_d;          // {remainder, quotient} shift register
  logic [31:0] bmag_q, bmag_d;      // divisor magnitude
  logic [31:0] a_q, a_d;            // raw dividend, returned on divide by zero
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic        bzero_q, bzero_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [1:0]  we_q, we_d;

  logic [63:0] mul_a_s, mul_b_s, prod_s, rq_next_s;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    neg32 = ~v + 32'd1;
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    if (sgn && v[31]) begin
      abs32 = neg32(v);
    end else begin
      abs32 = v;
    end
  endfunction

  // One restoring step: shift left, trial-subtract the divisor from the
  // upper 33 bits, keep the difference and set the quotient bit if it fits.
  function automatic logic [63:0] div_step(input logic [63:0] rq, input logic [31:0] d);
    logic [32:0] diff;
    diff = rq[63:31] - {1'b0, d};
    if (!diff[32]) begin
      div_step = {diff[31:0], rq[30:0], 1'b1};
    end else begin
      div_step = {rq[62:0], 1'b0};
    end
  endfunction

  // Next-state, datapath and write-pulse logic for both engine states.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rq_d      = rq_q;
    bmag_d    = bmag_q;
    a_d       = a_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    bzero_d   = bzero_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    we_d      = 2'b00;
    mul_a_s   = (op == OP_MULT) ? {{32{a[31]}}, a} : {32'd0, a};
    mul_b_s   = (op == OP_MULT) ? {{32{b[31]}}, b} : {32'd0, b};
    prod_s    = mul_a_s * mul_b_s;
    rq_next_s = div_step(rq_q, bmag_q);
    case (state_q)
      ST_IDLE: begin
        if (op_valid && !busy_q && !flush) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              hi_d = prod_s[63:32];
              lo_d = prod_s[31:0];
              we_d = 2'b11;
            end
            OP_DIV, OP_DIVU: begin
              state_d = ST_DIVIDE;
              busy_d  = 1'b1;
              cnt_d   = 5'd0;
              a_d     = a;
              bmag_d  = abs32(b, op == OP_DIV);
              rq_d    = {32'd0, abs32(a, op == OP_DIV)};
              negq_d  = (op == OP_DIV) && (a[31] ^ b[31]);
              negr_d  = (op == OP_DIV) && a[31];
              bzero_d = (b == 32'd0);
            end
            OP_MTHI: begin
              hi_d = a;
              we_d = 2'b10;
            end
            OP_MTLO: begin
              lo_d = a;
              we_d = 2'b01;
            end
            default: begin
              we_d = 2'b00;
            end
          endcase
        end else begin
          we_d = 2'b00;
        end
      end
      ST_DIVIDE: begin
        if (flush) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = 5'd0;
        end else begin
          rq_d  = rq_next_s;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            cnt_d   = 5'd0;
            we_d    = 2'b11;
            if (bzero_q) begin
              hi_d = a_q;
              lo_d = 32'hFFFF_FFFF;
            end else begin
              hi_d = negr_q ? neg32(rq_next_s[63:32]) : rq_next_s[63:32];
              lo_d = negq_q ? neg32(rq_next_s[31:0]) : rq_next_s[31:0];
            end
          end else begin
            busy_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cnt_d   = 5'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      rq_q    <= 64'd0;
      bmag_q  <= 32'd0;
      a_q     <= 32'd0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      bzero_q <= 1'b0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      we_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rq_q    <= rq_d;
      bmag_q  <= bmag_d;
      a_q     <= a_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      bzero_q <= bzero_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      we_q    <= we_d;
    end
  end

  assign busy = busy_q;
  assign hi_o = hi_q;
  assign lo_o = lo_q;
  assign we_o = we_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a vector table of single ops and divides,
// then hand sequences for flush, held requests, reset and pulse timing.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        busy;
  logic [31:0] hi_o, lo_o;
  logic [1:0]  we_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .hi_o(hi_o), .lo_o(lo_o), .we_o(we_o)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  we;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present an op for one clock edge; returns #1 into cycle N+1 with the
  // operand buses scrambled so late changes would corrupt a non-latched divide.
  task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    op_valid = 1'b1;
    op = o;
    a = va;
    b = vb;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    a = ~va;
    b = vb ^ 32'h5A5A_5A5A;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic ok;
    vecs[0]  = '{3'd0, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 2'b11};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2'b11};
    vecs[2]  = '{3'd0, 32'd7,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD, 2'b11};
    vecs[3]  = '{3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 2'b11};
    vecs[4]  = '{3'd4, 32'h1234_5678, 32'd9,        32'h1234_5678, 32'h0000_0000, 2'b10};
    vecs[5]  = '{3'd5, 32'hCAFE_BABE, 32'd9,        32'h1234_5678, 32'hCAFE_BABE, 2'b01};
    vecs[6]  = '{3'd6, 32'd1,        32'd2,        32'h1234_5678, 32'hCAFE_BABE, 2'b00};
    vecs[7]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 2'b11};
    vecs[8]  = '{3'd3, 32'd100,      32'd0,        32'd100,       32'hFFFF_FFFF, 2'b11};
    vecs[9]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 2'b11};
    vecs[10] = '{3'd3, 32'hFFFF_FFFF, 32'd10,       32'd5,         32'h1999_9999, 2'b11};
    vecs[11] = '{3'd2, 32'd100,      32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2, 2'b11};
    vecs[12] = '{3'd2, 32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFF2, 2'b11};
    vecs[13] = '{3'd2, 32'd0,        32'd5,        32'd0,         32'd0,         2'b11};
    vecs[14] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 2'b11};

    rst = 1'b1; op_valid = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset we", {30'd0, we_o}, 32'd0);
    chk("reset hi", hi_o, 32'd0);
    chk("reset lo", lo_o, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      if (vecs[i].op == 3'd2 || vecs[i].op == 3'd3) begin
        ok = 1'b1;
        for (int k = 0; k < 32; k++) begin
          if (busy !== 1'b1 || we_o !== 2'b00) ok = 1'b0;
          step();
        end
        chk($sformatf("v%0d busy window", i), {31'd0, ok}, 32'd1);
        chk($sformatf("v%0d busy at result", i), {31'd0, busy}, 32'd0);
      end
      chk($sformatf("v%0d we", i), {30'd0, we_o}, {30'd0, vecs[i].we});
      chk($sformatf("v%0d hi", i), hi_o, vecs[i].hi);
      chk($sformatf("v%0d lo", i), lo_o, vecs[i].lo);
      step();
      chk($sformatf("v%0d single pulse", i), {30'd0, we_o}, 32'd0);
    end

    // Flush at N+10: busy drops at N+11 and no pulse through N+40.
    issue(3'd2, 32'd50, 32'd3);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush busy low", {31'd0, busy}, 32'd0);
    ok = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (we_o !== 2'b00) ok = 1'b0;
      step();
    end
    chk("flush no pulse", {31'd0, ok}, 32'd1);
    chk("flush hi held", hi_o, 32'h4000_0000);

    // MTLO held during a divide: accepted at N+33, pulse at N+34.
    issue(3'd3, 32'd20, 32'd6);
    op_valid = 1'b1; op = 3'd5; a = 32'hABCD_0123;
    ok = 1'b1;
    for (int k = 0; k < 32; k++) begin
      if (busy !== 1'b1 || we_o !== 2'b00) ok = 1'b0;
      step();
    end
    chk("held busy window", {31'd0, ok}, 32'd1);
    chk("held div we", {30'd0, we_o}, 32'd3);
    chk("held div hi", hi_o, 32'd2);
    chk("held div lo", lo_o, 32'd3);
    step();
    op_valid = 1'b0;
    chk("held mtlo we", {30'd0, we_o}, 32'd1);
    chk("held mtlo lo", lo_o, 32'hABCD_0123);
    chk("held mtlo hi", hi_o, 32'd2);
    step();
    chk("held mtlo once", {30'd0, we_o}, 32'd0);

    // MTHI with flush in the same cycle is dropped.
    @(negedge clk);
    op_valid = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF; flush = 1'b1;
    step();
    op_valid = 1'b0; flush = 1'b0;
    chk("mthi flush we", {30'd0, we_o}, 32'd0);
    chk("mthi flush hi", hi_o, 32'd2);

    // Flush in the last divide cycle cancels the N+33 pulse.
    issue(3'd3, 32'd77, 32'd7);
    repeat (31) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("late flush we", {30'd0, we_o}, 32'd0);
    chk("late flush busy", {31'd0, busy}, 32'd0);
    chk("late flush lo", lo_o, 32'hABCD_0123);

    // Reset mid-divide clears everything and no pulse follows.
    issue(3'd2, 32'd1000, 32'd9);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid rst busy", {31'd0, busy}, 32'd0);
    chk("mid rst we", {30'd0, we_o}, 32'd0);
    chk("mid rst hi", hi_o, 32'd0);
    chk("mid rst lo", lo_o, 32'd0);
    ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (we_o !== 2'b00 || busy !== 1'b0) ok = 1'b0;
      step();
    end
    chk("mid rst quiet", {31'd0, ok}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
